// File: rtl/reaction_timer_ctrl_if.sv
// Signal bundle between the reaction-timer sequencer and its surroundings.
// Latency: none, wires only.
// Backpressure: none. Pulses are single-cycle and levels are held by the sequencer.
// Ports (slave = controller view):
//   in : start, stop (debounced one-cycle pulses), time_in[15:0] (timer count, 10 ms units)
//   out: timer_run, timer_clr, led, result[15:0], result_valid, best[15:0], cheat, timeout
interface reaction_timer_ctrl_if;
    logic        start;
    logic        stop;
    logic [15:0] time_in;
    logic        timer_run;
    logic        timer_clr;
    logic        led;
    logic [15:0] result;
    logic        result_valid;
    logic [15:0] best;
    logic        cheat;
    logic        timeout;

    // Button/timer side: drives the pulses and the count, observes the game outputs.
    modport master (
        output start, stop, time_in,
        input  timer_run, timer_clr, led, result, result_valid, best, cheat, timeout
    );

    // Controller side.
    modport slave (
        input  start, stop, time_in,
        output timer_run, timer_clr, led, result, result_valid, best, cheat, timeout
    );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: random pre-stimulus delay, stimulus LED, result/best capture, cheat and timeout detection.
// Latency: every output is registered, so a start/stop pulse shows on the outputs one clock after the edge that samples it.
// Backpressure: none. start is ignored mid-round, and stop is ignored outside DELAY/ARMED.
// Ports: clock, rst (sync, active-high); bus (reaction_timer_ctrl_if.slave) carries start/stop/time_in
//        in and timer_run/timer_clr/led/result/result_valid/best/cheat/timeout out.
module reaction_timer_ctrl #(
    parameter int TICK_DIV  = 312500,
    parameter int DELAY_MIN = 100,
    parameter int TIMEOUT   = 999
) (
    input  logic                 clock,
    input  logic                 rst,
    reaction_timer_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DELAY = 3'd1;
    localparam logic [2:0] ARMED = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] CHEAT = 3'd4;
    localparam logic [2:0] TMO   = 3'd5;

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     DMIN       = 16'(DELAY_MIN);
    localparam logic [15:0]     TMO_VAL    = 16'(TIMEOUT);

    logic [2:0]    state;
    logic [7:0]    lfsr;
    logic [PW-1:0] presc;
    logic [15:0]   delay_cnt;
    logic          tick;
    logic          lfsr_fb;

    logic          run_q;
    logic          clr_q;
    logic          led_q;
    logic [15:0]   result_q;
    logic          valid_q;
    logic [15:0]   best_q;
    logic          cheat_q;
    logic          tmo_q;

    // Taps for x^8+x^6+x^5+x^4+1. Seeded non-zero, and a maximal-length
    // sequence never enters the all-zero lock-up state.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign tick    = (presc == PRESC_LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= 8'h01;
            presc     <= '0;
            delay_cnt <= 16'd0;
            run_q     <= 1'b0;
            clr_q     <= 1'b0;
            led_q     <= 1'b0;
            result_q  <= 16'd0;
            valid_q   <= 1'b0;
            best_q    <= 16'hFFFF;
            cheat_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            // The random source runs in every state, so the delay depends
            // on how long the player idles between rounds.
            lfsr  <= {lfsr[6:0], lfsr_fb};
            presc <= tick ? '0 : presc + 1'b1;
            clr_q <= 1'b0;

            case (state)
                IDLE, DONE, CHEAT, TMO: begin
                    // start wins over a coincident stop here.
                    if (bus.start) begin
                        state     <= DELAY;
                        delay_cnt <= DMIN + {8'h00, lfsr};
                        // Restarting the prescaler makes the first tick land
                        // exactly TICK_DIV cycles after entry.
                        presc     <= '0;
                        clr_q     <= 1'b1;
                        valid_q   <= 1'b0;
                        cheat_q   <= 1'b0;
                        tmo_q     <= 1'b0;
                    end
                end

                DELAY: begin
                    // stop beats the final tick: pressing before the LED is a cheat.
                    if (bus.stop) begin
                        state   <= CHEAT;
                        cheat_q <= 1'b1;
                    end else if (tick) begin
                        delay_cnt <= delay_cnt - 16'd1;
                        if (delay_cnt == 16'd1) begin
                            state <= ARMED;
                            led_q <= 1'b1;
                            run_q <= 1'b1;
                            // Discard anything the timer counted during the delay.
                            clr_q <= 1'b1;
                        end
                    end
                end

                ARMED: begin
                    if (bus.stop) begin
                        state    <= DONE;
                        result_q <= bus.time_in;
                        valid_q  <= 1'b1;
                        led_q    <= 1'b0;
                        run_q    <= 1'b0;
                        // Strictly lower only; a tie keeps the existing best.
                        if (bus.time_in < best_q)
                            best_q <= bus.time_in;
                    end else if (bus.time_in >= TMO_VAL) begin
                        state    <= TMO;
                        result_q <= TMO_VAL;
                        tmo_q    <= 1'b1;
                        led_q    <= 1'b0;
                        run_q    <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    led_q <= 1'b0;
                    run_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.timer_run    = run_q;
    assign bus.timer_clr    = clr_q;
    assign bus.led          = led_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.best         = best_q;
    assign bus.cheat        = cheat_q;
    assign bus.timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl with a fast prescaler (TICK_DIV=4, DELAY_MIN=3, TIMEOUT=20).
// Expected values come from a game-level model: round length from the LFSR sequence position,
// result = sampled time, best = running minimum of completed rounds.
`define CK(tag, o, e) check(tag, 32'(o), 32'(e))

module tb_reaction_timer_ctrl;
    localparam int TICK_DIV  = 4;
    localparam int DELAY_MIN = 3;
    localparam int TIMEOUT   = 20;

    logic clock;
    logic rst;
    reaction_timer_ctrl_if bus ();

    reaction_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DELAY_MIN(DELAY_MIN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Number of non-reset edges since the last reset edge; the LFSR has
    // advanced exactly this many steps from its seed.
    int ncyc;
    always @(posedge clock) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    int          total = 0;
    int          npass = 0;
    int          nfail = 0;
    logic [15:0] m_best;
    logic [15:0] m_result;
    logic [7:0]  r;
    int          n_wait;

    // Per-cycle invariants: stimulus LED and timer enable move together, LFSR never locks up.
    always @(negedge clock) begin
        if (!rst) begin
            total++;
            if (bus.led !== bus.timer_run) begin
                nfail++;
                $error("FAIL led_eq_run led=%0b run=%0b", bus.led, bus.timer_run);
            end else begin
                npass++;
            end
            total++;
            if (dut.lfsr === 8'h00) begin
                nfail++;
                $error("FAIL lfsr_nonzero");
            end else begin
                npass++;
            end
        end
    end

    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < n; i++)
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Pulse start (optionally with stop); returns just after the edge that takes the round into DELAY.
    task automatic start_round(input logic with_stop);
        r = lfsr_after(ncyc);
        `CK("lfsr_at_start", dut.lfsr, r);
        n_wait = TICK_DIV * (DELAY_MIN + int'(r));
        bus.start = 1'b1;
        bus.stop  = with_stop;
        cyc();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        `CK("clr_on_delay_entry", bus.timer_clr, 1);
        `CK("valid_cleared", bus.result_valid, 0);
        `CK("cheat_cleared", bus.cheat, 0);
        `CK("timeout_cleared", bus.timeout, 0);
        `CK("led_off_in_delay", bus.led, 0);
    endtask

    // From the first DELAY cycle, run to exactly n_wait edges after the start edge.
    task automatic wait_arm();
        cyc();
        `CK("clr_one_cycle", bus.timer_clr, 0);
        for (int k = 2; k < n_wait; k++) cyc();
        `CK("led_before_arm", bus.led, 0);
        `CK("run_before_arm", bus.timer_run, 0);
        cyc();
        `CK("led_at_arm", bus.led, 1);
        `CK("run_at_arm", bus.timer_run, 1);
        `CK("clr_at_arm", bus.timer_clr, 1);
    endtask

    task automatic normal_round(input logic [15:0] tin, input logic with_stop, input logic poke_start);
        start_round(with_stop);
        wait_arm();
        bus.time_in = tin;
        idle_gap($urandom_range(0, 4));
        if (poke_start) begin
            bus.start = 1'b1;
            cyc();
            bus.start = 1'b0;
            `CK("start_ignored_armed_led", bus.led, 1);
            `CK("start_ignored_armed_clr", bus.timer_clr, 0);
        end
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        m_result = tin;
        if (tin < m_best) m_best = tin;
        `CK("result_done", bus.result, m_result);
        `CK("valid_done", bus.result_valid, 1);
        `CK("led_off_done", bus.led, 0);
        `CK("run_off_done", bus.timer_run, 0);
        bus.time_in = 16'd0;
        cyc();
        `CK("best_done", bus.best, m_best);
    endtask

    task automatic cheat_round(input logic at_final_tick);
        int k_stop;
        start_round(1'b0);
        k_stop = at_final_tick ? n_wait : int'($urandom_range(1, n_wait - 1));
        for (int k = 1; k < k_stop; k++) cyc();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        `CK("cheat_set", bus.cheat, 1);
        `CK("cheat_led_off", bus.led, 0);
        `CK("cheat_run_off", bus.timer_run, 0);
        `CK("cheat_result_kept", bus.result, m_result);
        idle_gap(8);
        `CK("cheat_led_never", bus.led, 0);
        `CK("cheat_best_kept", bus.best, m_best);
    endtask

    task automatic timeout_round();
        start_round(1'b0);
        wait_arm();
        for (int v = TIMEOUT - 5; v < TIMEOUT; v++) begin
            bus.time_in = 16'(v);
            cyc();
        end
        `CK("tmo_led_below_limit", bus.led, 1);
        bus.time_in = 16'(TIMEOUT);
        cyc();
        m_result = 16'(TIMEOUT);
        `CK("tmo_flag", bus.timeout, 1);
        `CK("tmo_result", bus.result, m_result);
        `CK("tmo_run_off", bus.timer_run, 0);
        `CK("tmo_led_off", bus.led, 0);
        bus.time_in = 16'd0;
        cyc();
        `CK("tmo_best_kept", bus.best, m_best);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.time_in = 16'd0;
        m_best      = 16'hFFFF;
        m_result    = 16'd0;
        r           = 8'h00;
        n_wait      = 0;

        // Reset state
        cyc();
        cyc();
        `CK("rst_led", bus.led, 0);
        `CK("rst_run", bus.timer_run, 0);
        `CK("rst_clr", bus.timer_clr, 0);
        `CK("rst_result", bus.result, 0);
        `CK("rst_valid", bus.result_valid, 0);
        `CK("rst_best", bus.best, 16'hFFFF);
        `CK("rst_cheat", bus.cheat, 0);
        `CK("rst_timeout", bus.timeout, 0);
        `CK("rst_lfsr", dut.lfsr, 8'h01);
        rst = 1'b0;
        idle_gap(3);

        // Normal rounds: first result sets best, a slower one leaves it
        normal_round(16'd7, 1'b0, 1'b0);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        `CK("stop_in_done_result", bus.result, m_result);
        `CK("stop_in_done_valid", bus.result_valid, 1);
        // start+stop together in DONE begins a new round; start poked while ARMED
        normal_round(16'd9, 1'b1, 1'b1);

        // Early press, then press on the very tick that would arm
        idle_gap($urandom_range(0, 15));
        cheat_round(1'b0);
        idle_gap($urandom_range(0, 15));
        cheat_round(1'b1);

        // Timeout, then stop in TMO must not disturb the result
        idle_gap($urandom_range(0, 15));
        timeout_round();
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        `CK("stop_in_tmo_result", bus.result, m_result);
        `CK("stop_in_tmo_flag", bus.timeout, 1);

        // Randomised mix of rounds
        for (int i = 0; i < 6; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            idle_gap($urandom_range(0, 15));
            case (kind)
                0:       normal_round(16'($urandom_range(0, TIMEOUT - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1:       cheat_round(1'b0);
                2:       cheat_round(1'b1);
                default: timeout_round();
            endcase
        end

        // Reset while ARMED loses everything including best
        idle_gap($urandom_range(0, 15));
        start_round(1'b0);
        wait_arm();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_best   = 16'hFFFF;
        m_result = 16'd0;
        `CK("midrst_led", bus.led, 0);
        `CK("midrst_run", bus.timer_run, 0);
        `CK("midrst_best", bus.best, 16'hFFFF);
        `CK("midrst_result", bus.result, 0);
        `CK("midrst_valid", bus.result_valid, 0);
        `CK("midrst_lfsr", dut.lfsr, 8'h01);

        // Fresh start after reset: any result becomes best
        idle_gap($urandom_range(0, 15));
        normal_round(16'($urandom_range(0, TIMEOUT - 1)), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
- Sequencing controller for the 10 ms slow-pulse timer (16-bit centisecond count, run/clear driven).
- Runs a reaction-time game: on start it waits a pseudo-random delay, then lights the stimulus LED and enables the timer. On stop it freezes the timer and latches the result.
- Detects early presses (cheat) and over-long waits (timeout), and keeps the best score.
- Sits between the debounced push-button pulses and the timer/display path.

Parameters:
- TICK_DIV, 312500, clock cycles per 10 ms tick for the internal delay prescaler (matches the timer).
- DELAY_MIN, 100, minimum pre-stimulus delay in ticks (1.00 s).
- TIMEOUT, 999, reaction count in ticks at which the round is abandoned (9.99 s).

Ports:
- clock, in, 1: system clock, rising edge.
- rst, in, 1: reset, synchronous, active-high. Also resets the LFSR, prescaler and best.
- start, in, 1: single-cycle debounced start pulse.
- stop, in, 1: single-cycle debounced stop pulse.
- time_in, in, 16: current timer count in 10 ms units.
- timer_run, out, 1: run enable to the timer.
- timer_clr, out, 1: one-cycle clear pulse to the timer.
- led, out, 1: stimulus LED.
- result, out, 16: latched reaction time in 10 ms units.
- result_valid, out, 1: high while in DONE.
- best, out, 16: lowest valid result since reset.
- cheat, out, 1: high while in CHEAT.
- timeout, out, 1: high while in TMO.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - state=IDLE
  - all 1-bit outputs 0; result=0, best=16'hFFFF
  - lfsr=8'h01, prescaler=0, delay_cnt=0
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every clock in every state.
  - Never reaches zero.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
  - Forced to 0 on every entry into DELAY, so the delay is exact.
- IDLE: start -> DELAY.
- DELAY:
  - Entry (from IDLE, DONE, CHEAT or TMO) on start:
    - delay_cnt <= DELAY_MIN + lfsr, using the 8-bit lfsr value at that edge zero-extended to 16 bits.
    - timer_clr=1 for exactly one cycle, the first cycle in DELAY.
    - result_valid, cheat and timeout clear.
  - Each tick decrements delay_cnt.
  - Round length is DELAY_MIN+r ticks, where r = lfsr value sampled at entry (1..255).
  - stop -> CHEAT, regardless of the tick.
  - Tick with delay_cnt==1 (and no stop) -> ARMED.
  - stop and final tick in the same cycle: stop wins -> CHEAT.
- ARMED:
  - led=1 and timer_run=1 from the first ARMED cycle.
  - timer_clr pulses for one cycle on entry to discard any residual count.
  - stop -> DONE:
    - result <= time_in as sampled at that edge.
    - led and timer_run drop the next cycle.
  - time_in >= TIMEOUT (and no stop) -> TMO, with led and timer_run dropping.
  - stop and the timeout condition in the same cycle: stop wins.
- DONE:
  - result_valid=1.
  - Entry cycle: if result < best, best <= result. Ties keep best; result=0 is legal.
  - start -> DELAY.
  - stop ignored.
- CHEAT: cheat=1, result unchanged, best unchanged; start -> DELAY; stop ignored.
- TMO: timeout=1, result <= TIMEOUT on entry, best unchanged; start -> DELAY; stop ignored.
- start is ignored in DELAY and ARMED; there is no restart mid-round.
- start and stop together:
  - IDLE/DONE/CHEAT/TMO: start wins.
  - DELAY/ARMED: stop wins.
- rst mid-round: next cycle in IDLE with all outputs at reset values; best is lost.
- All outputs are registered; no combinational path from start/stop to outputs.
- Widths:
  - delay_cnt is 16 bits.
  - DELAY_MIN+255 must fit in 16 bits.
  - TICK_DIV counter width is clog2(TICK_DIV).

Test Plan (bench uses TICK_DIV=4, DELAY_MIN=3, TIMEOUT=20):
- Reset: assert rst 2 cycles -> state IDLE, led=0, timer_run=0, result=0, best=FFFF, lfsr=01.
- Normal round: start at t0; expect timer_clr at t0+1 and led=1 after exactly (3+r)*4 cycles, with r = lfsr at t0. Drive stop with time_in=7 -> result=7, result_valid=1, best=7. A second round with time_in=9 -> result=9, best stays 7.
- Cheat: stop during DELAY -> cheat=1, led never rises, best unchanged. Stop coincident with the final tick -> CHEAT, not ARMED.
- Timeout: stay in ARMED until time_in reaches 20 -> timeout=1, result=20, timer_run=0, best unchanged.
- Simultaneous/ignored inputs: start+stop together in DONE -> new round (DELAY). start pulsed in ARMED -> no effect. stop in DONE -> result unchanged.
- Mid-round reset: rst asserted in ARMED -> next cycle led=0, timer_run=0, best=FFFF, state IDLE.
